// File: rtl/mux_nto1_arb_pkg.sv
// Shared types and limits for the N-to-1 registered arbitrating multiplexer.
package mux_pkg;

  // Arbitration mode selector values for the MODE parameter.
  typedef enum logic {
    MUX_MODE_SEL = 1'b0,
    MUX_MODE_RR  = 1'b1
  } mux_mode_e;

  // Largest supported channel count.
  localparam int unsigned MUX_MAX_N = 16;

endpackage

// File: rtl/mux_nto1_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after PTR, wrapping at N-1.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     REQ,
  input  logic [SEL_W-1:0] PTR,
  output logic [SEL_W-1:0] GNT,
  output logic             GNT_VLD
);

  // One extra bit so PTR + k (at most 2N-2) never overflows before the wrap.
  logic [SEL_W:0] idx;

  // Scan channels in priority order PTR, PTR+1, ..., wrapping; keep the first hit.
  always_comb begin
    GNT     = '0;
    GNT_VLD = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = {1'b0, PTR} + (SEL_W + 1)'(k);
      if (idx >= (SEL_W + 1)'(N)) begin
        idx = idx - (SEL_W + 1)'(N);
      end
      if (!GNT_VLD && REQ[idx[SEL_W-1:0]]) begin
        GNT     = idx[SEL_W-1:0];
        GNT_VLD = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_arb.sv
// N-input registered multiplexer with per-channel valid/ready, explicit-select or
// round-robin grant, and a one-entry output register with its own handshake.
module mux_nto1_arb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 4,
  parameter  int unsigned MODE  = 0,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N*WIDTH-1:0]   IN_DATA,
  input  logic [N-1:0]         IN_VALID,
  output logic [N-1:0]         IN_READY,
  input  logic [SEL_W-1:0]     SEL,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic [SEL_W-1:0]     OUT_CH,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  localparam bit IS_RR = (MODE == 32'(MUX_MODE_RR));

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic [SEL_W-1:0] rr_gnt;
  logic             rr_vld;
  logic             sel_vld_c;
  logic [SEL_W-1:0] gnt_c;
  logic             gnt_vld_c;
  logic             load_c;
  logic             xfer_c;

  // Round-robin candidate; only consulted when the block runs in round-robin mode.
  rr_arbiter #(.N(N)) u_rr_arbiter (
    .REQ     (IN_VALID),
    .PTR     (ptr_q),
    .GNT     (rr_gnt),
    .GNT_VLD (rr_vld)
  );

  // Grant selection, load enable and per-channel ready.
  always_comb begin
    sel_vld_c = 1'b0;
    gnt_c     = '0;
    gnt_vld_c = 1'b0;
    // Out-of-range selects never grant.
    if (32'(SEL) < N) begin
      sel_vld_c = IN_VALID[SEL];
    end
    if (IS_RR) begin
      gnt_c     = rr_gnt;
      gnt_vld_c = rr_vld;
    end else if (sel_vld_c) begin
      gnt_c     = SEL;
      gnt_vld_c = 1'b1;
    end
    load_c   = !out_valid_q || OUT_READY;
    xfer_c   = load_c && gnt_vld_c;
    IN_READY = (RST_N && xfer_c) ? (N'(1) << gnt_c) : '0;
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_c) begin
      out_data_d  = IN_DATA[32'(gnt_c)*WIDTH +: WIDTH];
      out_ch_d    = gnt_c;
      out_valid_d = 1'b1;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
    // Pointer advances past the winner only on an actual transfer, so stalls keep order.
    if (IS_RR && xfer_c) begin
      ptr_d = (32'(gnt_c) == N - 1) ? '0 : gnt_c + SEL_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Bench for mux_nto1_arb: three instances (select N=4, select N=5, round-robin N=4)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_mux_nto1_arb;

  localparam int unsigned W  = 32;
  localparam int          NI = 3;

  logic clk;
  logic rst_n;

  logic [16*W-1:0] in_data   [NI];
  logic [15:0]     in_valid  [NI];
  logic [3:0]      sel       [NI];
  logic            out_ready [NI];

  logic [3:0]   rdy0;
  logic [4:0]   rdy1;
  logic [3:0]   rdy2;
  logic [W-1:0] od0, od1, od2;
  logic [1:0]   oc0;
  logic [2:0]   oc1;
  logic [1:0]   oc2;
  logic         ov0, ov1, ov2;

  int passed;
  int total;

  mux_nto1_arb #(.WIDTH(W), .N(4), .MODE(0)) u_sel4 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data[0][4*W-1:0]), .IN_VALID(in_valid[0][3:0]),
    .IN_READY(rdy0), .SEL(sel[0][1:0]), .OUT_DATA(od0), .OUT_CH(oc0), .OUT_VALID(ov0),
    .OUT_READY(out_ready[0]));

  mux_nto1_arb #(.WIDTH(W), .N(5), .MODE(0)) u_sel5 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data[1][5*W-1:0]), .IN_VALID(in_valid[1][4:0]),
    .IN_READY(rdy1), .SEL(sel[1][2:0]), .OUT_DATA(od1), .OUT_CH(oc1), .OUT_VALID(ov1),
    .OUT_READY(out_ready[1]));

  mux_nto1_arb #(.WIDTH(W), .N(4), .MODE(1)) u_rr4 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data[2][4*W-1:0]), .IN_VALID(in_valid[2][3:0]),
    .IN_READY(rdy2), .SEL(sel[2][1:0]), .OUT_DATA(od2), .OUT_CH(oc2), .OUT_VALID(ov2),
    .OUT_READY(out_ready[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int n_of(int i);
    return (i == 1) ? 5 : 4;
  endfunction

  function automatic bit is_rr(int i);
    return i == 2;
  endfunction

  function automatic logic [15:0] act_rdy(int i);
    case (i)
      0:       return 16'(rdy0);
      1:       return 16'(rdy1);
      default: return 16'(rdy2);
    endcase
  endfunction

  function automatic logic [31:0] act_data(int i);
    case (i)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [31:0] act_ch(int i);
    case (i)
      0:       return 32'(oc0);
      1:       return 32'(oc1);
      default: return 32'(oc2);
    endcase
  endfunction

  function automatic logic act_valid(int i);
    case (i)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s u%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
  endtask

  // Behavioural model state: what the output register must hold, plus the rotation start.
  logic        m_valid [NI];
  logic [31:0] m_data  [NI];
  int          m_ch    [NI];
  int          m_ptr   [NI];

  // Winner by the rules: explicit select if in range and valid, else first valid from pointer.
  function automatic int model_grant(int i);
    int n;
    n = n_of(i);
    if (!is_rr(i)) begin
      if (int'(sel[i]) < n && in_valid[i][sel[i]]) return int'(sel[i]);
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      if (in_valid[i][(m_ptr[i] + k) % n]) return (m_ptr[i] + k) % n;
    end
    return -1;
  endfunction

  // Compare every instance every cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int          g;
      logic [15:0] er;
      logic        load;
      if (!rst_n) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
        m_ch[i]    = 0;
        m_ptr[i]   = 0;
      end
      load = !m_valid[i] || out_ready[i];
      g    = model_grant(i);
      er   = (rst_n && load && g >= 0) ? (16'(1) << g) : 16'(0);
      chk("in_ready",  i, 32'(act_rdy(i)),   32'(er));
      chk("out_valid", i, 32'(act_valid(i)), 32'(m_valid[i]));
      chk("out_data",  i, act_data(i),       m_data[i]);
      chk("out_ch",    i, act_ch(i),         32'(m_ch[i]));
      if (rst_n) begin
        if (er != 16'(0)) begin
          m_valid[i] = 1'b1;
          m_data[i]  = in_data[i][g*W +: W];
          m_ch[i]    = g;
          if (is_rr(i)) m_ptr[i] = (g + 1) % n_of(i);
        end else if (out_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = '0;
      sel[i]       = '0;
      out_ready[i] = 1'b1;
      for (int c = 0; c < 16; c++) begin
        in_data[i][c*W +: W] = 32'((i + 1) << 28) | 32'(c * 32'h11);
      end
    end
    in_data[0][2*W +: W] = 32'hDEADBEEF;
    in_valid[0] = 16'h000F;
    in_valid[1] = 16'h001F;
    in_valid[2] = 16'h000F;
    sel[0] = 4'd2;
    sel[1] = 4'd5;

    // Reset held with every channel requesting.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", 0, 32'(ov0), 32'd0);
    chk("rst_out_data",  0, od0, 32'd0);
    chk("rst_in_ready",  0, 32'(rdy0), 32'd0);
    chk("rst_in_ready",  2, 32'(rdy2), 32'd0);

    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("sel2_in_ready",  0, 32'(rdy0), 32'h4);
    chk("sel5_in_ready",  1, 32'(rdy1), 32'h0);
    chk("rr_first_ready", 2, 32'(rdy2), 32'h1);

    // Full-rate round robin over 1111; explicit-select variations run alongside.
    for (int k = 0; k < 8; k++) begin
      tick();
      case (k)
        1: begin sel[0] = 4'd3; in_valid[0] = 16'h0007; end
        2: sel[1] = 4'd4;
        3: sel[0] = 4'd0;
        4: begin out_ready[0] = 1'b0; sel[1] = 4'd7; end
        6: out_ready[0] = 1'b1;
        7: in_valid[2] = 16'h000A;
        default: ;
      endcase
      @(negedge clk);
      chk("rr_seq_valid", 2, 32'(ov2), 32'd1);
      chk("rr_seq_ch",    2, 32'(oc2), 32'(k % 4));
      if (k == 0) begin
        chk("sel2_data",  0, od0, 32'hDEADBEEF);
        chk("sel2_ch",    0, 32'(oc0), 32'd2);
        chk("sel2_valid", 0, 32'(ov0), 32'd1);
        chk("sel5_valid", 1, 32'(ov1), 32'd0);
      end
      if (k == 2) begin
        chk("nogrant_valid", 0, 32'(ov0), 32'd0);
        chk("nogrant_hold",  0, od0, 32'hDEADBEEF);
      end
      if (k == 3) begin
        chk("sel4_ch",   1, 32'(oc1), 32'd4);
        chk("sel4_data", 1, od1, 32'h20000044);
      end
    end

    // Sparse requests 1010 from pointer 0; stall after the fourth word.
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) out_ready[2] = 1'b0;
      @(negedge clk);
      chk("rr_sparse_ch", 2, 32'(oc2), (k % 2 == 1) ? 32'd3 : 32'd1);
    end

    // Back-pressure: word held, no ready; release resumes the pre-stall order.
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) out_ready[2] = 1'b1;
      @(negedge clk);
      chk("stall_ch",    2, 32'(oc2), 32'd3);
      chk("stall_data",  2, od2, 32'h30000033);
      chk("stall_valid", 2, 32'(ov2), 32'd1);
      chk("stall_ready", 2, 32'(rdy2), (k == 2) ? 32'h2 : 32'h0);
    end
    tick();
    @(negedge clk);
    chk("resume_ch", 2, 32'(oc2), 32'd1);
    tick();
    @(negedge clk);
    chk("resume_ch2", 2, 32'(oc2), 32'd3);

    // Reset mid-stream discards the held word and the pointer.
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 2, 32'(ov2), 32'd0);
    chk("midrst_data",  2, od2, 32'd0);
    chk("midrst_ch",    2, 32'(oc2), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("postrst_ch", 2, 32'(oc2), 32'd1);

    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
